// File: rtl/array_port_sequencer.sv
// array_port_sequencer: stream-to-array scheduler for a 2-D array datapath.
// Elements arrive one per valid/ready handshake, fill the load registers row-major and drive
// arr_a_o. After the last element, one EXEC cycle captures arr_b_i into the result registers,
// which are then streamed out one element per handshake. The datapath never sees a partial frame.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   in_valid_i      producer element valid
//   in_ready_o      sequencer accepts an element (high only while loading)
//   in_data_i       input element, row-major order
//   out_valid_o     result element valid (high only while draining)
//   out_ready_i     consumer accepts an element
//   out_data_o      result element, row-major order
//   out_last_o      high with the final element (index DIM0*DIM1-1)
//   arr_a_o         load registers presented to the datapath
//   arr_b_i         datapath result (combinational)
//   busy_o          high in EXEC or DRAIN
//
// Optional feature, enabled by defining ARRAY_SEQ_LAST_EN:
//   in_last_i       marks the final element of a frame; an early in_last zero-fills the rest
//   frame_err_o     sticky framing error (early in_last, or missing in_last on the last element)
module array_port_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIM0  = 3,
  parameter int unsigned DIM1  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [WIDTH-1:0]                      in_data_i,
`ifdef ARRAY_SEQ_LAST_EN
  input  logic                                  in_last_i,
  output logic                                  frame_err_o,
`endif
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [WIDTH-1:0]                      out_data_o,
  output logic                                  out_last_o,
  output logic [DIM0-1:0][DIM1-1:0][WIDTH-1:0] arr_a_o,
  input  logic [DIM0-1:0][DIM1-1:0][WIDTH-1:0] arr_b_i,
  output logic                                  busy_o
);

  localparam int unsigned N    = DIM0 * DIM1;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StLoad, StExec, StDrain} state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]            idx_q;
  // Flat row-major storage: element k sits at [k / DIM1][k % DIM1] of the packed array.
  logic [N-1:0][WIDTH-1:0]    load_q;
  logic [N-1:0][WIDTH-1:0]    res_q;

  logic in_hs, out_hs, at_last, frame_end, drain_end;

  assign in_hs     = in_valid_i && in_ready_o;
  assign out_hs    = out_valid_o && out_ready_i;
  assign at_last   = (idx_q == LastIdx);
`ifdef ARRAY_SEQ_LAST_EN
  assign frame_end = in_hs && (at_last || in_last_i);
`else
  assign frame_end = in_hs && at_last;
`endif
  assign drain_end = out_hs && at_last;

  assign arr_a_o = load_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (frame_end) state_d = StExec;
      StExec:  state_d = StDrain;
      StDrain: if (drain_end) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Outputs depend only on registered state, so out_valid_o has no path from out_ready_i.
  always_comb begin
    in_ready_o  = (state_q == StLoad);
    out_valid_o = (state_q == StDrain);
    busy_o      = (state_q == StExec) || (state_q == StDrain);
    out_last_o  = (state_q == StDrain) && at_last;
    out_data_o  = '0;
    if (state_q == StDrain) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (idx_q == IdxW'(k)) out_data_o = res_q[k];
      end
    end
  end

  // Index, load and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      load_q <= '0;
      res_q  <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_hs) begin
            for (int unsigned k = 0; k < N; k++) begin
              if (idx_q == IdxW'(k)) begin
                load_q[k] <= in_data_i;
`ifdef ARRAY_SEQ_LAST_EN
              end else if (in_last_i && (IdxW'(k) > idx_q)) begin
                // Early end of frame: entries beyond the last accepted one read as zero.
                load_q[k] <= '0;
`endif
              end
            end
            idx_q <= frame_end ? '0 : idx_q + 1'b1;
          end
        end
        StExec: res_q <= arr_b_i;
        StDrain: begin
          if (out_hs) idx_q <= drain_end ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARRAY_SEQ_LAST_EN
  logic frame_err_q;

  // Error when in_last disagrees with the element position.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else if (in_hs && (in_last_i != at_last)) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_array_port_sequencer.sv
module tb_array_port_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIM0  = 3;
  localparam int unsigned DIM1  = 2;

  typedef logic [WIDTH-1:0] frame_t [6];

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WIDTH-1:0]                      in_data;
  logic                                  in_last;
  logic                                  frame_err;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WIDTH-1:0]                      out_data;
  logic                                  out_last;
  logic [DIM0-1:0][DIM1-1:0][WIDTH-1:0] arr_a;
  logic [DIM0-1:0][DIM1-1:0][WIDTH-1:0] arr_b;
  logic                                  busy;
  logic [WIDTH-1:0]                      mask;

  int n_chk  = 0;
  int n_pass = 0;

  // Datapath model: element-wise XOR with a bench-controlled mask (mask 0 gives b = a).
  assign arr_b = arr_a ^ {(DIM0 * DIM1){mask}};

  always #5 clk = ~clk;

  array_port_sequencer #(
    .WIDTH(WIDTH),
    .DIM0 (DIM0),
    .DIM1 (DIM1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
`ifdef ARRAY_SEQ_LAST_EN
    .in_last_i  (in_last),
    .frame_err_o(frame_err),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .arr_a_o    (arr_a),
    .arr_b_i    (arr_b),
    .busy_o     (busy)
  );

`ifndef ARRAY_SEQ_LAST_EN
  assign frame_err = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the edge that completes the handshake.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit gaps);
    for (int i = 0; i < 6; i++) begin
      send(f[i], (i == 5));
      if (gaps && i < 5) begin
        chk($sformatf("gap%0d_busy", i), {31'd0, busy}, 32'd0);
        step();
      end
    end
  endtask

  task automatic recv_frame(input frame_t e, output int waits);
    int guard;
    waits     = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      while (!out_valid && guard < 50) begin
        step();
        guard++;
      end
      waits += guard;
      if (guard >= 50) chk("recv_timeout", 32'd1, 32'd0);
      chk($sformatf("out%0d_data", i), {28'd0, out_data}, {28'd0, e[i]});
      chk($sformatf("out%0d_last", i), {31'd0, out_last}, (i == 5) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  frame_t f, e;
  int     waits;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    mask      = '0;
    repeat (3) step();

    // Reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_arr_a", {8'd0, arr_a}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Basic frame, back-to-back input, b = a
    f = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    out_ready = 1'b1;
    send_frame(f, 1'b0);
    chk("basic_arr_a21", {28'd0, arr_a[2][1]}, 32'h6);
    chk("basic_arr_a00", {28'd0, arr_a[0][0]}, 32'h1);
    chk("basic_arr_a10", {28'd0, arr_a[1][0]}, 32'h3);
    chk("basic_exec_in_ready", {31'd0, in_ready}, 32'd0);
    chk("basic_exec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("basic_exec_busy", {31'd0, busy}, 32'd1);
    recv_frame(f, waits);
    chk("basic_drain_waits", waits, 32'd1);  // only the single EXEC cycle
    chk("basic_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("basic_done_busy", {31'd0, busy}, 32'd0);
    chk("basic_frame_err", {31'd0, frame_err}, 32'd0);

    // Output backpressure; the mask changes after capture so results must come from registers
    mask      = 4'h3;
    out_ready = 1'b0;
    send_frame(f, 1'b0);
    step();  // EXEC -> DRAIN
    mask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_out_data", i), {28'd0, out_data}, 32'h2);
      chk($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      step();
    end
    e = '{4'h2, 4'h1, 4'h0, 4'h7, 4'h6, 4'h5};
    recv_frame(e, waits);
    chk("bp_arr_a_stable", {28'd0, arr_a[2][1]}, 32'h6);

    // Input bubbles
    f = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    send_frame(f, 1'b1);
    chk("bub_busy_after6", {31'd0, busy}, 32'd1);
    chk("bub_arr_a11", {28'd0, arr_a[1][1]}, 32'hA);
    recv_frame(f, waits);

    // Reset after three elements
    send(4'hD, 1'b0);
    send(4'hE, 1'b0);
    send(4'hF, 1'b0);
    rst = 1'b1;
    step();
    chk("rstl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstl_arr_a", {8'd0, arr_a}, 32'd0);
    rst = 1'b0;
    f = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    send_frame(f, 1'b0);
    chk("rstl_arr_a00", {28'd0, arr_a[0][0]}, 32'hD);
    recv_frame(f, waits);

    // Reset in mid-DRAIN
    f = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    send_frame(f, 1'b0);
    step();
    step();
    step();  // two outputs consumed
    chk("rstd_pre_data", {28'd0, out_data}, 32'h3);
    rst = 1'b1;
    step();
    chk("rstd_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstd_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstd_out_data", {28'd0, out_data}, 32'd0);
    chk("rstd_arr_a", {8'd0, arr_a}, 32'd0);
    rst = 1'b0;

    // Back-to-back frames
    f = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    send_frame(f, 1'b0);
    recv_frame(f, waits);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    send_frame(f, 1'b0);
    recv_frame(f, waits);
    chk("b2b_waits", waits, 32'd1);

`ifdef ARRAY_SEQ_LAST_EN
    // Early in_last on element 3: remaining entries zero-filled
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b1);
    chk("early_busy", {31'd0, busy}, 32'd1);
    chk("early_frame_err", {31'd0, frame_err}, 32'd1);
    e = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0};
    recv_frame(e, waits);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", {31'd0, frame_err}, 32'd0);
    // Missing in_last on element 6
    f = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
    for (int i = 0; i < 6; i++) send(f[i], 1'b0);
    chk("miss_frame_err", {31'd0, frame_err}, 32'd1);
    recv_frame(f, waits);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
